// File: rtl/board_pkg.sv
// Shared types for the board writer: cell encoding, board geometry and
// clear-index helpers.
`timescale 1ns/1ps
package board_pkg;

  localparam int BOARD_N = 5;
  localparam int CELLS   = BOARD_N * BOARD_N;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_t;

  typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam board_t EMPTY_BOARD = '{default: EMPTY};

  // Row-major mapping of the 0..24 clear index onto board coordinates.
  function automatic logic [2:0] idx_row(input logic [4:0] idx);
    logic [4:0] q;
    q = idx / 5'd5;
    return q[2:0];
  endfunction

  function automatic logic [2:0] idx_col(input logic [4:0] idx);
    logic [4:0] r;
    r = idx % 5'd5;
    return r[2:0];
  endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchronizer for an idle-high async input, followed by a
// registered falling-edge detector.
`timescale 1ns/1ps
module sync_fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic fall_pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync2_d_reg;

  // Flops reset high so an idle input does not look like an edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      sync2_d_reg <= 1'b1;
      fall_pulse  <= 1'b0;
    end else begin
      sync1_reg   <= async_in;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
      fall_pulse  <= sync2_d_reg & ~sync2_reg;
    end
  end

endmodule

// File: rtl/board_writer.sv
// Shadow/display double-buffered 5x5 game board; the shadow is copied to the
// display on a synchronized vsync falling edge whenever it has changed.
`timescale 1ns/1ps
module board_writer
  import board_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_row,
  input  logic [2:0]            wr_col,
  input  logic [1:0]            wr_data,
  input  logic                  clear_req,
  input  logic                  vsync,
  output logic [1:0][4:0][4:0]  frame_matrix,
  output logic                  dirty,
  output logic                  commit_pulse,
  output logic                  err_pulse
);

  localparam logic [2:0] LAST_RC  = 3'(BOARD_N - 1);
  localparam logic [4:0] LAST_IDX = 5'(CELLS - 1);

  state_t     state_reg;
  logic [4:0] clr_idx_reg;
  board_t     shadow_reg;
  board_t     frame_reg;
  logic       dirty_reg;
  logic       commit_pulse_reg;
  logic       err_pulse_reg;
  logic       vsync_fall;
  logic       wr_fire;
  logic       in_range;
  logic       commit_now;

  sync_fall_detect u_vsync_fall (
    .clk        (clk),
    .rst        (rst),
    .async_in   (vsync),
    .fall_pulse (vsync_fall)
  );

  assign wr_ready   = !rst && (state_reg == IDLE) && !clear_req;
  assign wr_fire    = wr_valid && wr_ready;
  assign in_range   = (wr_row <= LAST_RC) && (wr_col <= LAST_RC);
  assign commit_now = vsync_fall && (state_reg == IDLE) && dirty_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      clr_idx_reg      <= '0;
      shadow_reg       <= EMPTY_BOARD;
      frame_reg        <= EMPTY_BOARD;
      dirty_reg        <= 1'b0;
      commit_pulse_reg <= 1'b0;
      err_pulse_reg    <= 1'b0;
    end else begin
      commit_pulse_reg <= commit_now;
      err_pulse_reg    <= wr_fire && !in_range;

      // Commit copies the pre-write shadow; a same-cycle write below re-sets dirty.
      if (commit_now) begin
        frame_reg <= shadow_reg;
        dirty_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (clear_req) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
          end else if (wr_fire && in_range) begin
            shadow_reg[wr_row][wr_col] <= cell_t'(wr_data);
            dirty_reg                  <= 1'b1;
          end
        end
        CLEAR: begin
          shadow_reg[idx_row(clr_idx_reg)][idx_col(clr_idx_reg)] <= EMPTY;
          dirty_reg <= 1'b1;
          if (clr_idx_reg == LAST_IDX) begin
            state_reg   <= IDLE;
            clr_idx_reg <= '0;
          end else begin
            clr_idx_reg <= clr_idx_reg + 5'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dirty        = dirty_reg;
  assign commit_pulse = commit_pulse_reg;
  assign err_pulse    = err_pulse_reg;

  // frame_matrix is bit-plane major: frame_matrix[bit][row][col].
  for (genvar gi = 0; gi < BOARD_N; gi++) begin : g_row
    for (genvar gj = 0; gj < BOARD_N; gj++) begin : g_col
      logic [1:0] cell_bits;
      assign cell_bits             = frame_reg[gi][gj];
      assign frame_matrix[0][gi][gj] = cell_bits[0];
      assign frame_matrix[1][gi][gj] = cell_bits[1];
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: directed scenarios plus random traffic,
// checked through a per-cycle expectation queue drained by a monitor.
`timescale 1ns/1ps
module tb_board_writer;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic [2:0]           wr_row = '0;
  logic [2:0]           wr_col = '0;
  logic [1:0]           wr_data = '0;
  logic                 clear_req = 1'b0;
  logic                 vsync = 1'b1;
  logic [1:0][4:0][4:0] frame_matrix;
  logic                 dirty;
  logic                 commit_pulse;
  logic                 err_pulse;

  board_writer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .clear_req    (clear_req),
    .vsync        (vsync),
    .frame_matrix (frame_matrix),
    .dirty        (dirty),
    .commit_pulse (commit_pulse),
    .err_pulse    (err_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic        commit;
    logic        err;
    logic        dirty;
    logic [49:0] frame;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: board contents and pending vsync falls by cycle number.
  int m_sh[5][5];
  int m_fm[5][5];
  bit m_idle = 1'b1;
  int m_ci = 0;
  bit m_dirty = 1'b0;
  bit m_last_vs = 1'b1;
  int falls[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [49:0] dut_frame();
    logic [49:0] f;
    f = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        f[(r*5+c)*2 +: 2] = {frame_matrix[1][r][c], frame_matrix[0][r][c]};
    return f;
  endfunction

  function automatic logic [49:0] model_frame();
    logic [49:0] f;
    f = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        f[(r*5+c)*2 +: 2] = 2'(m_fm[r][c]);
    return f;
  endfunction

  function automatic int dut_cell(input int r, input int c);
    return int'({frame_matrix[1][r][c], frame_matrix[0][r][c]});
  endfunction

  // Drive one cycle of inputs, check wr_ready, advance the model to the next edge.
  task automatic step(input bit r_i, input bit wv, input int row, input int col,
                      input int d, input bit clr, input bit vs);
    exp_t e;
    bit   ready, fire, inr, commit;
    int   n;
    @(negedge clk);
    rst = r_i; wr_valid = wv; wr_row = 3'(row); wr_col = 3'(col);
    wr_data = 2'(d); clear_req = clr; vsync = vs;
    #1;
    ready = !r_i && m_idle && !clr;
    chk("wr_ready", 64'(wr_ready), 64'(ready));
    n = cyc + 1;
    e = '0;
    if (r_i) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          m_sh[r][c] = 0;
          m_fm[r][c] = 0;
        end
      m_idle = 1'b1; m_ci = 0; m_dirty = 1'b0; m_last_vs = 1'b1;
      falls.delete();
    end else begin
      fire = wv && ready;
      inr  = (row < 5) && (col < 5);
      commit = 1'b0;
      foreach (falls[i]) if (falls[i] == n - 3) commit = m_idle && m_dirty;
      if (commit) begin
        m_fm = m_sh;
        m_dirty = 1'b0;
      end
      e.commit = commit;
      e.err    = fire && !inr;
      if (m_idle) begin
        if (clr) begin
          m_idle = 1'b0;
          m_ci = 0;
        end else if (fire && inr) begin
          m_sh[row][col] = d;
          m_dirty = 1'b1;
        end
      end else begin
        m_sh[m_ci / 5][m_ci % 5] = 0;
        m_dirty = 1'b1;
        m_ci++;
        if (m_ci == 25) begin
          m_idle = 1'b1;
          m_ci = 0;
        end
      end
      if (!vs && m_last_vs) falls.push_back(n);
      m_last_vs = vs;
      while (falls.size() > 0 && falls[0] < n - 3) void'(falls.pop_front());
    end
    e.dirty = m_dirty;
    e.frame = model_frame();
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic vfall(input int lows);
    for (int i = 0; i < lows; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("commit_pulse", 64'(commit_pulse), 64'(e.commit));
      chk("err_pulse", 64'(err_pulse), 64'(e.err));
      chk("dirty", 64'(dirty), 64'(e.dirty));
      chk("frame_matrix", 64'(dut_frame()), 64'(e.frame));
    end
  end

  initial begin
    logic [49:0] saved;
    int ph, per, t;
    bit vs;

    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    settle();
    chk("reset_frame", 64'(dut_frame()), 64'd0);
    chk("reset_dirty", 64'(dirty), 64'd0);
    idle(2);

    // Write (2,3)=HIT, commit three cycles after the fall is sampled.
    step(0, 1, 2, 3, 2, 0, 1);
    settle();
    chk("dirty_after_write", 64'(dirty), 64'd1);
    vfall(4);
    settle();
    chk("commit_cell_2_3", 64'(dut_cell(2, 3)), 64'd2);
    chk("commit_pulse_at_fall+3", 64'(commit_pulse), 64'd1);
    chk("dirty_cleared", 64'(dirty), 64'd0);
    idle(4);

    // Out-of-range write: error strobe, no dirty, no commit on next fall.
    step(0, 1, 5, 0, 1, 0, 1);
    settle();
    chk("err_pulse_oor", 64'(err_pulse), 64'd1);
    chk("dirty_after_oor", 64'(dirty), 64'd0);
    idle(2);
    vfall(4);
    idle(4);

    // Fill the board, then clear with a simultaneous write that must be refused.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) step(0, 1, r, c, ((r + c) % 3) + 1, 0, 1);
    settle();
    saved = dut_frame();
    step(0, 1, 1, 1, 3, 1, 1);
    idle(2);
    vfall(4);
    idle(19);
    settle();
    chk("frame_held_in_clear", 64'(dut_frame()), 64'(saved));
    idle(3);
    vfall(4);
    settle();
    chk("commit_all_zero", 64'(dut_frame()), 64'd0);
    idle(4);

    // Write on the commit cycle: old value committed, new value stays dirty.
    step(0, 1, 0, 0, 1, 0, 1);
    idle(2);
    vfall(3);
    step(0, 1, 0, 0, 3, 0, 0);
    settle();
    chk("commit_old_value", 64'(dut_cell(0, 0)), 64'd1);
    chk("dirty_after_race", 64'(dirty), 64'd1);
    idle(3);
    vfall(4);
    settle();
    chk("commit_new_value", 64'(dut_cell(0, 0)), 64'd3);
    idle(3);

    // Reset in the middle of a clear (index 12).
    step(0, 1, 4, 4, 2, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    idle(12);
    step(1, 0, 0, 0, 0, 0, 1);
    settle();
    chk("midclear_rst_frame", 64'(dut_frame()), 64'd0);
    chk("midclear_rst_dirty", 64'(dirty), 64'd0);
    chk("midclear_rst_commit", 64'(commit_pulse), 64'd0);
    chk("midclear_rst_err", 64'(err_pulse), 64'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Random traffic.
    ph = 0;
    per = 12;
    for (int i = 0; i < 1500; i++) begin
      int r, c;
      vs = (ph < 3) ? 1'b0 : 1'b1;
      ph++;
      if (ph >= per) begin
        ph = 0;
        per = $urandom_range(8, 24);
      end
      r = ($urandom % 10 == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      c = ($urandom % 10 == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      step(($urandom % 400) == 0, ($urandom % 10) < 6, r, c, $urandom_range(0, 3),
           ($urandom % 40) == 0, vs);
    end
    idle(4);

    t = 0;
    while (exp_q.size() > 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 The block SHALL use one clock, `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Ports SHALL be exactly as follows (clock and reset first):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  cell-write request
- wr_ready  out  1  block can accept a write this cycle
- wr_row  in  3  target row, 0..4 valid
- wr_col  in  3  target column, 0..4 valid
- wr_data  in  2  cell value (cell_t)
- clear_req  in  1  one-cycle request to zero the shadow board
- vsync  in  1  active-low VGA vertical sync, asynchronous to clk
- frame_matrix  out  [1:0][4:0][4:0]  display board, stable between commits
- dirty  out  1  shadow board differs from last committed frame
- commit_pulse  out  1  one-cycle strobe when frame_matrix is updated
- err_pulse  out  1  one-cycle strobe for an accepted write with out-of-range coordinates

Function
REQ-003 The block SHALL hold a shadow board of 25 cells, 2 bits each, and a display board that drives frame_matrix.
REQ-004 The state machine SHALL have two states, IDLE and CLEAR.
REQ-005 In IDLE, wr_ready SHALL be 1 unless clear_req is 1 in the same cycle.
REQ-006 A write SHALL be accepted on any cycle where wr_valid and wr_ready are both 1; the shadow cell [wr_row][wr_col] SHALL hold wr_data from the next cycle, and dirty SHALL be set.
REQ-007 An accepted write with wr_row>4 or wr_col>4 SHALL leave the shadow board unchanged, SHALL leave dirty unchanged, and SHALL raise err_pulse for one cycle on the following cycle.
REQ-008 When clear_req is 1 in IDLE, the state SHALL move to CLEAR; clear SHALL take priority over a simultaneous wr_valid, which is not accepted.
REQ-009 CLEAR SHALL zero one shadow cell per cycle using a 5-bit index from 0 to 24 in row-major order, SHALL hold wr_ready at 0, SHALL set dirty, and SHALL return to IDLE after index 24 (25 cycles in CLEAR).
REQ-010 clear_req SHALL be ignored while in CLEAR.
REQ-011 vsync SHALL pass through a 2-flop synchronizer followed by a falling-edge detector.
REQ-012 A commit SHALL occur 3 clk cycles after the vsync falling edge is sampled by the first sync flop, provided the state is IDLE and dirty is 1.
REQ-013 A commit SHALL copy the whole shadow board into frame_matrix in one cycle, clear dirty, and pulse commit_pulse for one cycle.
REQ-014 If a write is accepted in the same cycle as a commit:
- the commit SHALL copy the pre-write shadow;
- the write SHALL land in the shadow;
- dirty SHALL remain 1.
REQ-015 A vsync edge detected while in CLEAR or with dirty=0 SHALL be dropped and SHALL NOT be deferred; the next edge retries.
REQ-016 frame_matrix SHALL change only on a commit cycle or on reset.

Reset
REQ-017 On rst, the following SHALL hold:
- shadow, frame_matrix and the clear index SHALL be 0;
- the state SHALL be IDLE;
- dirty, commit_pulse and err_pulse SHALL be 0;
- the sync flops SHALL be 1 (vsync idle);
- wr_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-018 rst asserted mid-CLEAR or on a commit cycle SHALL override all other activity.

Structure
REQ-019 Package board_pkg SHALL define:
- cell_t enum (EMPTY=0, SHIP=1, HIT=2, MISS=3);
- BOARD_N=5;
- board_t as a 5x5 array of cell_t.
REQ-020 The synchronizer and edge detector SHALL be one sub-module, sync_fall_detect, with ports clk, rst, async_in and fall_pulse.
REQ-021 The implementation SHALL stay within 120-400 lines of RTL.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Write (2,3)=HIT, then drop vsync → frame_matrix[2][3]=2 exactly 3 cycles after the fall; commit_pulse high 1 cycle; dirty 1→0.
- Write (5,0)=SHIP → err_pulse for 1 cycle, dirty stays 0; the next vsync fall produces no commit_pulse.
- Fill the board, pulse clear_req with wr_valid=1 → wr_ready=0 for 25 cycles, the write is not accepted, a vsync fall during CLEAR leaves frame_matrix unchanged, and the next fall commits all zeros.
- Write (0,0)=MISS accepted on the commit cycle → committed [0][0] holds the old value, dirty=1; the next fall commits MISS.
- Assert rst at clear index 12 → all outputs 0, state IDLE, wr_ready=1 on the cycle after rst deasserts.
